// File: rtl/sram_bus_responder.sv
// rtl/sram_bus_responder.sv - asynchronous-SRAM-style bus responder backed by an internal word store
module sram_bus_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] addrBus,
    inout  wire  [15:0] dataBus,
    input  logic        memEnable,
    input  logic        memRead,
    input  logic        memWrite,
    output logic        busy,
    output logic        driving,
    output logic        protoErr,
    output logic [7:0]  writeCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        DRIVE   = 2'd2,
        WR_HOLD = 2'd3
    } state_t;

    localparam int DEPTH = 1 << ADDR_BITS;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [15:0]            rdata_q, rdata_d;
    logic [15:0]            wdata_q, wdata_d;
    logic                   protoerr_q, protoerr_d;
    logic [7:0]             wcount_q, wcount_d;
    logic                   busy_q, busy_d;
    logic                   commit;

    logic [15:0]            store_mem [0:DEPTH-1];

    logic                   in_range;
    logic                   rd_req;
    logic                   wr_req;
    logic                   both_low;
    logic                   rd_strobe_on;
    logic                   addr_moved;

    assign in_range     = (addrBus[17:ADDR_BITS] == '0);
    assign both_low     = !memEnable && !memRead && !memWrite;
    assign rd_req       = !memEnable && !memRead && memWrite && in_range;
    assign wr_req       = !memEnable && !memWrite && memRead && in_range;
    assign rd_strobe_on = !memEnable && !memRead;
    assign addr_moved   = (addrBus != {{(18 - ADDR_BITS){1'b0}}, addr_q});

    // Bus drive is gated combinationally so the responder lets go in the same cycle the strobes rise
    assign driving    = (state_q == DRIVE) && rd_strobe_on;
    assign dataBus    = driving ? rdata_q : 16'hzzzz;
    assign busy       = busy_q;
    assign protoErr   = protoerr_q;
    assign writeCount = wcount_q;

    // Next-state and datapath decisions for the bus protocol
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        wdata_d    = wdata_q;
        protoerr_d = protoerr_q;
        wcount_d   = wcount_q;
        commit     = 1'b0;

        if (both_low) begin
            // Read and write strobed together: flag it and drop whatever was in flight
            protoerr_d = 1'b1;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_req) begin
                        addr_d  = addrBus[ADDR_BITS-1:0];
                        cnt_d   = 4'(READ_LATENCY);
                        state_d = RD_WAIT;
                    end else if (wr_req) begin
                        addr_d  = addrBus[ADDR_BITS-1:0];
                        wdata_d = dataBus;
                        state_d = WR_HOLD;
                    end
                end
                RD_WAIT: begin
                    if (!rd_strobe_on) begin
                        state_d = IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        rdata_d = store_mem[addr_q];
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (!rd_strobe_on) begin
                        state_d = IDLE;
                    end else if (addr_moved) begin
                        // A move to an out-of-range address ends the read rather than re-arming it
                        if (in_range) begin
                            addr_d  = addrBus[ADDR_BITS-1:0];
                            cnt_d   = 4'(READ_LATENCY);
                            state_d = RD_WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                WR_HOLD: begin
                    if (!memWrite && !memEnable) begin
                        wdata_d = dataBus;
                    end else begin
                        commit   = 1'b1;
                        wcount_d = wcount_q + 8'd1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // Control and datapath registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= 4'd0;
            rdata_q    <= 16'h0000;
            wdata_q    <= 16'h0000;
            protoerr_q <= 1'b0;
            wcount_q   <= 8'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            wdata_q    <= wdata_d;
            protoerr_q <= protoerr_d;
            wcount_q   <= wcount_d;
            busy_q     <= busy_d;
        end
    end

    // Backing store keeps its contents across reset; a reset edge cancels a pending commit
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            store_mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_sram_bus_responder.sv
// tb/tb_sram_bus_responder.sv - directed self-checking bench for sram_bus_responder
module tb_sram_bus_responder;

    logic        clk;
    logic        rst;
    logic [17:0] addrBus;
    wire  [15:0] dataBus;
    logic        memEnable;
    logic        memRead;
    logic        memWrite;
    logic        busy;
    logic        driving;
    logic        protoErr;
    logic [7:0]  writeCount;

    logic [15:0] tb_data;
    logic        tb_oe;

    int n_cmp;
    int n_bad;

    assign dataBus = tb_oe ? tb_data : 16'hzzzz;

    sram_bus_responder #(.ADDR_BITS(8), .READ_LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .addrBus    (addrBus),
        .dataBus    (dataBus),
        .memEnable  (memEnable),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .busy       (busy),
        .driving    (driving),
        .protoErr   (protoErr),
        .writeCount (writeCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        memEnable = 1'b1;
        memRead   = 1'b1;
        memWrite  = 1'b1;
        tb_oe     = 1'b0;
    endtask

    // Full write cycle: WE low for n edges holding data, then release (commit edge)
    task automatic do_write(input logic [17:0] a, input logic [15:0] d, input int n);
        addrBus = a; tb_data = d; tb_oe = 1'b1;
        memEnable = 1'b0; memRead = 1'b1; memWrite = 1'b0;
        for (int i = 0; i < n; i++) step();
        bus_idle();
        step();
    endtask

    // Start a read and run until the DRIVE state should be reached (capture + 3 edges)
    task automatic read_to_drive(input logic [17:0] a);
        addrBus = a; tb_oe = 1'b0;
        memEnable = 1'b0; memRead = 1'b0; memWrite = 1'b1;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_idle(); addrBus = 18'h0; tb_data = 16'h0;
        step(); step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (driving !== 1'b0) begin n_bad++; $display("FAIL reset_driving: got %b want 0", driving); end
        n_cmp++; if (protoErr !== 1'b0) begin n_bad++; $display("FAIL reset_protoErr: got %b want 0", protoErr); end
        n_cmp++; if (writeCount !== 8'd0) begin n_bad++; $display("FAIL reset_writeCount: got %0d want 0", writeCount); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        addrBus = 18'h005; tb_data = 16'h1111; tb_oe = 1'b1;
        memEnable = 1'b0; memRead = 1'b1; memWrite = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL write_busy: got %b want 1", busy); end
        step();
        tb_data = 16'hBEEF;
        step();
        n_cmp++; if (writeCount !== 8'd0) begin n_bad++; $display("FAIL write_precommit_count: got %0d want 0", writeCount); end
        bus_idle();
        step();
        n_cmp++; if (writeCount !== 8'd1) begin n_bad++; $display("FAIL write_count: got %0d want 1", writeCount); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL write_idle: got %b want 0", busy); end
        do_write(18'h006, 16'h1234, 2);
        n_cmp++; if (writeCount !== 8'd2) begin n_bad++; $display("FAIL write_count2: got %0d want 2", writeCount); end
    endtask

    task automatic test_read();
        addrBus = 18'h005; tb_oe = 1'b0;
        memEnable = 1'b0; memRead = 1'b0; memWrite = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL read_busy: got %b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (driving !== 1'b0) begin n_bad++; $display("FAIL read_early_drive[%0d]: got %b want 0", i, driving); end
            step();
        end
        n_cmp++; if (driving !== 1'b1) begin n_bad++; $display("FAIL read_drive: got %b want 1", driving); end
        n_cmp++; if (dataBus !== 16'hBEEF) begin n_bad++; $display("FAIL read_data: got %h want beef", dataBus); end
        memRead = 1'b1;
        #1;
        n_cmp++; if (driving !== 1'b0) begin n_bad++; $display("FAIL read_release: got %b want 0", driving); end
        bus_idle();
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL read_idle: got %b want 0", busy); end
    endtask

    task automatic test_readdress();
        read_to_drive(18'h005);
        n_cmp++; if (dataBus !== 16'hBEEF) begin n_bad++; $display("FAIL readdr_first: got %h want beef", dataBus); end
        addrBus = 18'h006;
        step();
        n_cmp++; if (driving !== 1'b0) begin n_bad++; $display("FAIL readdr_released: got %b want 0", driving); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL readdr_busy: got %b want 1", busy); end
        step(); step();
        n_cmp++; if (driving !== 1'b0) begin n_bad++; $display("FAIL readdr_early: got %b want 0", driving); end
        step();
        n_cmp++; if (driving !== 1'b1) begin n_bad++; $display("FAIL readdr_drive: got %b want 1", driving); end
        n_cmp++; if (dataBus !== 16'h1234) begin n_bad++; $display("FAIL readdr_data: got %h want 1234", dataBus); end
        bus_idle();
        step();
    endtask

    task automatic test_out_of_range();
        addrBus = 18'h100; tb_oe = 1'b0;
        memEnable = 1'b0; memRead = 1'b0; memWrite = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if ({busy, driving} !== 2'b00) begin n_bad++; $display("FAIL oor_read[%0d]: got %b want 00", i, {busy, driving}); end
        end
        bus_idle();
        step();
        addrBus = 18'h100; tb_data = 16'hDEAD; tb_oe = 1'b1;
        memEnable = 1'b0; memWrite = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL oor_write_busy: got %b want 0", busy); end
        step();
        bus_idle();
        step();
        n_cmp++; if (writeCount !== 8'd2) begin n_bad++; $display("FAIL oor_write_count: got %0d want 2", writeCount); end
    endtask

    task automatic test_back_to_back();
        addrBus = 18'h008; tb_data = 16'h4321; tb_oe = 1'b1;
        memEnable = 1'b0; memRead = 1'b1; memWrite = 1'b0;
        step(); step();
        // Commit edge and read strobe presented together; the read captures on the following edge
        tb_oe = 1'b0; memWrite = 1'b1; memRead = 1'b0;
        step();
        n_cmp++; if (writeCount !== 8'd3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", writeCount); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_commit_idle: got %b want 0", busy); end
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (driving !== 1'b1) begin n_bad++; $display("FAIL b2b_drive: got %b want 1", driving); end
        n_cmp++; if (dataBus !== 16'h4321) begin n_bad++; $display("FAIL b2b_data: got %h want 4321", dataBus); end
        bus_idle();
        step();
    endtask

    task automatic test_proto();
        addrBus = 18'h005; tb_data = 16'h0000; tb_oe = 1'b1;
        memEnable = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        step();
        n_cmp++; if (protoErr !== 1'b1) begin n_bad++; $display("FAIL proto_set: got %b want 1", protoErr); end
        n_cmp++; if ({busy, driving} !== 2'b00) begin n_bad++; $display("FAIL proto_idle: got %b want 00", {busy, driving}); end
        bus_idle();
        step(); step();
        n_cmp++; if (protoErr !== 1'b1) begin n_bad++; $display("FAIL proto_sticky: got %b want 1", protoErr); end
        // Write in progress, then read strobe joins: the write must be abandoned
        addrBus = 18'h005; tb_data = 16'h5555; tb_oe = 1'b1;
        memEnable = 1'b0; memWrite = 1'b0;
        step();
        memRead = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL proto_abandon: got %b want 0", busy); end
        bus_idle();
        step();
        n_cmp++; if (writeCount !== 8'd3) begin n_bad++; $display("FAIL proto_count: got %0d want 3", writeCount); end
        read_to_drive(18'h005);
        n_cmp++; if (dataBus !== 16'hBEEF) begin n_bad++; $display("FAIL proto_nowrite: got %h want beef", dataBus); end
        bus_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (protoErr !== 1'b0) begin n_bad++; $display("FAIL proto_clear: got %b want 0", protoErr); end
        step();
    endtask

    task automatic test_reset_wrhold();
        do_write(18'h007, 16'h0777, 1);
        n_cmp++; if (writeCount !== 8'd1) begin n_bad++; $display("FAIL rstwr_pre_count: got %0d want 1", writeCount); end
        rst = 1'b1; step(); rst = 1'b0;
        addrBus = 18'h007; tb_data = 16'hAAAA; tb_oe = 1'b1;
        memEnable = 1'b0; memRead = 1'b1; memWrite = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        n_cmp++; if ({busy, driving, protoErr} !== 3'b000) begin n_bad++; $display("FAIL rstwr_flags: got %b want 000", {busy, driving, protoErr}); end
        n_cmp++; if (writeCount !== 8'd0) begin n_bad++; $display("FAIL rstwr_count: got %0d want 0", writeCount); end
        bus_idle();
        rst = 1'b0;
        step();
        n_cmp++; if (writeCount !== 8'd0) begin n_bad++; $display("FAIL rstwr_nocommit: got %0d want 0", writeCount); end
        read_to_drive(18'h007);
        n_cmp++; if (dataBus !== 16'h0777) begin n_bad++; $display("FAIL rstwr_store: got %h want 0777", dataBus); end
        bus_idle();
        step();
    endtask

    task automatic test_reset_drive();
        read_to_drive(18'h006);
        n_cmp++; if (driving !== 1'b1) begin n_bad++; $display("FAIL rstdrv_pre: got %b want 1", driving); end
        rst = 1'b1;
        step();
        n_cmp++; if (driving !== 1'b0) begin n_bad++; $display("FAIL rstdrv_release: got %b want 0", driving); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstdrv_busy: got %b want 0", busy); end
        bus_idle();
        rst = 1'b0;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_write();
        test_read();
        test_readdress();
        test_out_of_range();
        test_back_to_back();
        test_proto();
        test_reset_wrhold();
        test_reset_drive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_bus_responder.md
SRAM_BUS_RESPONDER -- requirements
Module: sram_bus_responder

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter ADDR_BITS, 8, number of decoded word-address bits; backing store depth is 2^ADDR_BITS x 16.
REQ-003 Parameter READ_LATENCY, 2, wait cycles (0..15) between read capture and data drive.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 addrBus  input  18  word address from the memory-bus initiator.
REQ-007 dataBus  inout  16  shared data bus; driven only as specified in REQ-016, high-Z otherwise.
REQ-008 memEnable  input  1  chip enable, active-low.
REQ-009 memRead  input  1  output enable, active-low.
REQ-010 memWrite  input  1  write enable, active-low.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 driving  output  1  high exactly when dataBus is driven by this block.
REQ-013 protoErr  output  1  sticky; set when memRead and memWrite are both low with memEnable low.
REQ-014 writeCount  output  8  committed-write counter; wraps 255 -> 0.

Function
REQ-015 FSM states SHALL be IDLE, RD_WAIT, DRIVE, WR_HOLD.
REQ-016 dataBus SHALL be driven from the read-data register iff state==DRIVE and memEnable==0 and memRead==0 (combinational gating, so release occurs in the same cycle the strobe deasserts).
REQ-017 A request is in range iff addrBus[17:ADDR_BITS]==0; out-of-range requests SHALL be ignored (remain IDLE, no write, no drive).
REQ-018 IDLE, memEnable=0, memRead=0, memWrite=1, in range: capture addrBus[ADDR_BITS-1:0], load counter=READ_LATENCY, go RD_WAIT.
REQ-019 RD_WAIT: counter>0 -> decrement; counter==0 -> load read-data register from store[captured addr], go DRIVE; DRIVE therefore entered READ_LATENCY+1 edges after the capture edge.
REQ-020 RD_WAIT or DRIVE, memEnable or memRead deasserted: go IDLE at next edge.
REQ-021 DRIVE, addrBus differs from captured address (strobes still low): recapture, reload counter, go RD_WAIT (bus released while waiting).
REQ-022 IDLE, memEnable=0, memWrite=0, memRead=1, in range: capture address and dataBus, go WR_HOLD.
REQ-023 WR_HOLD while memWrite=0 and memEnable=0: re-capture dataBus each edge (address held from entry).
REQ-024 WR_HOLD, memWrite or memEnable returns high: commit last captured data to store[captured addr], increment writeCount, go IDLE (commit on the deasserting edge).
REQ-025 memEnable=0, memRead=0, memWrite=0 sampled in any state: set protoErr, abandon operation without write, go IDLE; dataBus not driven.
REQ-026 A read of an address SHALL return the most recently committed write to it; a commit and a subsequent capture on the next edge SHALL see the new value.
REQ-027 Store contents are not initialised by reset; reads of never-written locations are don't-care.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, busy=0, driving=0, protoErr=0, writeCount=0, counter=0; store contents preserved.
REQ-029 Reset during WR_HOLD SHALL discard the pending write (writeCount unchanged from 0, store unchanged).
REQ-030 Reset during DRIVE SHALL release dataBus after the reset edge.

Verification
REQ-031 Write 0xBEEF to addr 0x005 (WE low 3 cycles, data 0x1111 then 0xBEEF) -> store[5]=0xBEEF, writeCount=1.
REQ-032 Read addr 0x005, READ_LATENCY=2 -> driving=1 exactly 3 edges after capture, dataBus=0xBEEF; OE high -> high-Z same cycle.
REQ-033 During DRIVE change address to 0x006 (holding 0x1234) -> bus released, re-drives 0x1234 after 3 edges.
REQ-034 Read/write to addr 0x100 (ADDR_BITS=8) -> busy stays 0, no drive, writeCount unchanged.
REQ-035 OE and WE both low with CE low -> protoErr=1 and sticky, no write, no drive; rst clears it.
REQ-036 rst asserted mid-WR_HOLD with data 0xAAAA at addr 0x007 -> store[7] unchanged, all outputs at reset values.
